// File: rtl/result_averager_if.sv
// rtl/result_averager_if.sv - upstream/downstream handshake bundle for the result averager
interface result_averager_if;
    logic        dav_in_;
    logic        rfd_in;
    logic [15:0] data_in;
    logic        dav_out_;
    logic        rfd_out;
    logic [15:0] avg;
    logic [15:0] max;

    modport master (
        output dav_in_, data_in, rfd_out,
        input  rfd_in, dav_out_, avg, max
    );

    modport slave (
        input  dav_in_, data_in, rfd_out,
        output rfd_in, dav_out_, avg, max
    );
endinterface

// File: rtl/result_averager.sv
// rtl/result_averager.sv - groups of four samples in, registered mean and maximum out
module result_averager (
    input  logic              clock,
    input  logic              reset_,
    result_averager_if.slave  bus
);
    typedef enum logic [1:0] {IN_WAIT, IN_ACK, OUT_WAIT, OUT_ACK} state_t;

    state_t      state_q, state_d;
    logic [17:0] sum_q, sum_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] run_max_q, run_max_d;
    logic [15:0] avg_q, avg_d;
    logic [15:0] max_q, max_d;
    logic        rfd_in_q, rfd_in_d;
    logic        dav_out_q, dav_out_d;

    logic        group_full;
    assign group_full = (count_q == 3'd4);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IN_WAIT;
            sum_q     <= '0;
            count_q   <= '0;
            run_max_q <= '0;
            avg_q     <= '0;
            max_q     <= '0;
            rfd_in_q  <= 1'b1;
            dav_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            run_max_q <= run_max_d;
            avg_q     <= avg_d;
            max_q     <= max_d;
            rfd_in_q  <= rfd_in_d;
            dav_out_q <= dav_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IN_WAIT:  if (!bus.dav_in_) state_d = IN_ACK;
            IN_ACK:   if (bus.dav_in_)  state_d = group_full ? OUT_WAIT : IN_WAIT;
            OUT_WAIT: if (bus.rfd_out)  state_d = OUT_ACK;
            OUT_ACK:  if (!bus.rfd_out) state_d = IN_WAIT;
            default:                    state_d = IN_WAIT;
        endcase
    end

    // Upstream samples are only taken in IN_WAIT, so a sample offered during
    // the output handshake waits with rfd_in high until the group is drained.
    always_comb begin
        sum_d     = sum_q;
        count_d   = count_q;
        run_max_d = run_max_q;
        avg_d     = avg_q;
        max_d     = max_q;
        rfd_in_d  = rfd_in_q;
        dav_out_d = dav_out_q;
        case (state_q)
            IN_WAIT: begin
                if (!bus.dav_in_) begin
                    sum_d    = sum_q + {2'b00, bus.data_in};
                    count_d  = count_q + 3'd1;
                    rfd_in_d = 1'b0;
                    if (count_q == 3'd0 || bus.data_in > run_max_q) begin
                        run_max_d = bus.data_in;
                    end
                end
            end
            IN_ACK: begin
                if (bus.dav_in_) begin
                    rfd_in_d = 1'b1;
                    if (group_full) begin
                        avg_d = sum_q[17:2];
                        max_d = run_max_q;
                    end
                end
            end
            OUT_WAIT: begin
                dav_out_d = !bus.rfd_out;
            end
            OUT_ACK: begin
                if (!bus.rfd_out) begin
                    dav_out_d = 1'b1;
                    sum_d     = '0;
                    count_d   = '0;
                end else begin
                    dav_out_d = 1'b0;
                end
            end
            default: begin
                rfd_in_d  = 1'b1;
                dav_out_d = 1'b1;
            end
        endcase
    end

    assign bus.rfd_in   = rfd_in_q;
    assign bus.dav_out_ = dav_out_q;
    assign bus.avg      = avg_q;
    assign bus.max      = max_q;
endmodule

// File: tb/tb_result_averager.sv
// tb/tb_result_averager.sv - scoreboard bench for result_averager
module tb_result_averager;
    logic clock;
    logic reset_;
    result_averager_if bus ();

    result_averager dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    int n_groups = 0;
    int up_max   = 0;
    int dn_max   = 0;
    logic ds_hold = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input int dly);
        int t;
        repeat (dly) @(negedge clock);
        bus.data_in = d;
        bus.dav_in_ = 1'b0;
        t = 0;
        while (bus.rfd_in !== 1'b0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (t >= 300) check("ack_timeout", 32'(bus.rfd_in), 0);
        repeat (dly) @(negedge clock);
        bus.dav_in_ = 1'b1;
        t = 0;
        while (bus.rfd_in !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("release_timeout", 32'(bus.rfd_in), 1);
    endtask

    task automatic expect_group(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        logic [17:0] s;
        logic [15:0] m;
        s = 18'(a) + 18'(b) + 18'(c) + 18'(d);
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        exp_q.push_back({s[17:2], m});
        n_groups++;
    endtask

    task automatic send_group(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        expect_group(a, b, c, d);
        send(a, $urandom_range(0, up_max));
        send(b, $urandom_range(0, up_max));
        send(c, $urandom_range(0, up_max));
        send(d, $urandom_range(0, up_max));
    endtask

    // Downstream consumer: raise rfd_out, take the result when dav_out_ falls, release.
    initial begin
        logic [31:0] e;
        int t;
        bus.rfd_out = 1'b0;
        forever begin
            @(negedge clock);
            if (!ds_hold) begin
                repeat ($urandom_range(0, dn_max)) @(negedge clock);
                bus.rfd_out = !ds_hold;
                while (bus.dav_out_ !== 1'b0) begin
                    @(negedge clock);
                    bus.rfd_out = !ds_hold;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(n_out), 32'(n_groups));
                end else begin
                    e = exp_q.pop_front();
                    check("avg", 32'(bus.avg), 32'(e[31:16]));
                    check("max", 32'(bus.max), 32'(e[15:0]));
                end
                n_out++;
                repeat ($urandom_range(0, dn_max)) @(negedge clock);
                bus.rfd_out = 1'b0;
                t = 0;
                while (bus.dav_out_ !== 1'b1 && t < 20) begin
                    @(negedge clock);
                    t++;
                end
                check("dav_out_release", 32'(bus.dav_out_), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int viol;
        int base;
        int t;
        reset_      = 1'b0;
        bus.dav_in_ = 1'b1;
        bus.data_in = '0;
        repeat (3) @(negedge clock);
        check("rst_rfd_in", 32'(bus.rfd_in), 1);
        check("rst_dav_out", 32'(bus.dav_out_), 1);
        check("rst_avg", 32'(bus.avg), 0);
        check("rst_max", 32'(bus.max), 0);
        reset_ = 1'b1;
        @(negedge clock);

        send_group(16'd100, 16'd200, 16'd300, 16'd400);
        send_group(16'd1, 16'd2, 16'd3, 16'd4);
        send_group(16'd65535, 16'd65535, 16'd65535, 16'd65535);
        send_group(16'd9, 16'd9, 16'd3, 16'd9);

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("drain_directed", 32'(exp_q.size()), 0);
        repeat (10) @(negedge clock);

        // Downstream stalled: the next sample must not be taken until the output drains.
        ds_hold = 1'b1;
        repeat (2) @(negedge clock);
        base = n_out;
        send_group(16'd380, 16'd50, 16'd400, 16'd400);
        expect_group(16'd10, 16'd20, 16'd30, 16'd40);
        bus.data_in = 16'd10;
        bus.dav_in_ = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.rfd_in !== 1'b1 || bus.dav_out_ !== 1'b1) viol++;
        end
        check("hold_no_ack_no_out", 32'(viol), 0);
        ds_hold = 1'b0;
        t = 0;
        while (bus.rfd_in !== 1'b0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("fifth_ack_after_output", 32'(n_out - base), 1);
        bus.dav_in_ = 1'b1;
        t = 0;
        while (bus.rfd_in !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        send(16'd20, 0);
        send(16'd30, 1);
        send(16'd40, 2);
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("drain_hold", 32'(exp_q.size()), 0);
        repeat (10) @(negedge clock);

        // Reset mid-group discards the partial sum.
        send(16'd1000, 1);
        send(16'd2000, 1);
        #2 reset_ = 1'b0;
        #1;
        check("midrst_rfd_in", 32'(bus.rfd_in), 1);
        check("midrst_dav_out", 32'(bus.dav_out_), 1);
        check("midrst_avg", 32'(bus.avg), 0);
        check("midrst_max", 32'(bus.max), 0);
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        #1;
        check("postrst_avg", 32'(bus.avg), 0);
        check("postrst_rfd_in", 32'(bus.rfd_in), 1);
        @(negedge clock);
        send_group(16'd7, 16'd7, 16'd7, 16'd11);

        up_max = 6;
        dn_max = 6;
        for (int g = 0; g < 16; g++) begin
            send_group(16'($urandom), 16'($urandom), 16'($urandom_range(0, 300)), 16'($urandom));
        end
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        check("drain_random", 32'(exp_q.size()), 0);
        repeat (20) @(negedge clock);
        check("groups_out", 32'(n_out), 32'(n_groups));
        check("idle_rfd_in", 32'(bus.rfd_in), 1);
        check("idle_dav_out", 32'(bus.dav_out_), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
